// File: rtl/shift_register_universal.sv
// Universal WIDTH-bit shift register with single-step ops and a counted burst-shift engine.
// Define SHIFT_REG_ROTATE_EN to build ROL/ROR; otherwise those opcodes hold.
module shift_register_universal #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_par_in,
  input  logic             i_ser_in_l,
  input  logic             i_ser_in_r,
  input  logic             i_burst_start,
  input  logic [CW-1:0]    i_burst_len,
  input  logic             i_burst_dir,
  output logic [WIDTH-1:0] o_par_out,
  output logic             o_ser_out_l,
  output logic             o_ser_out_r,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [CW-1:0] MaxLen = CW'(WIDTH);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic             r_dir;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_op_next;
  logic [CW-1:0]    w_sat_len;

  assign w_shl     = {r_q[WIDTH-2:0], i_ser_in_l};
  assign w_shr     = {i_ser_in_r, r_q[WIDTH-1:1]};
  assign w_sat_len = (i_burst_len > MaxLen) ? MaxLen : i_burst_len;

  always_comb begin
    w_op_next = r_q;
    case (i_op)
      3'b001:  w_op_next = i_par_in;
      3'b010:  w_op_next = w_shl;
      3'b011:  w_op_next = w_shr;
      3'b100:  w_op_next = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
`ifdef SHIFT_REG_ROTATE_EN
      3'b101:  w_op_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      3'b110:  w_op_next = {r_q[0], r_q[WIDTH-1:1]};
`endif
      3'b111:  w_op_next = '0;
      default: w_op_next = r_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_q     <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          // A burst request wins over any op presented in the same cycle.
          if (i_burst_start) begin
            if (i_burst_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_dir   <= i_burst_dir;
              r_cnt   <= w_sat_len;
              r_busy  <= 1'b1;
              r_state <= StRun;
            end
          end else if (i_en) begin
            r_q <= w_op_next;
          end
        end
        StRun: begin
          r_q   <= r_dir ? w_shr : w_shl;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_par_out   = r_q;
  assign o_ser_out_l = r_q[WIDTH-1];
  assign o_ser_out_r = r_q[0];
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_shift_register_universal.sv
// Self-checking bench for shift_register_universal (WIDTH=8): directed test-plan steps
// followed by random traffic compared against a behavioural model.
module tb_shift_register_universal;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk;
  logic          reset;
  logic          i_en;
  logic [2:0]    i_op;
  logic [W-1:0]  i_par_in;
  logic          i_ser_in_l;
  logic          i_ser_in_r;
  logic          i_burst_start;
  logic [CW-1:0] i_burst_len;
  logic          i_burst_dir;
  logic [W-1:0]  o_par_out;
  logic          o_ser_out_l;
  logic          o_ser_out_r;
  logic          o_busy;
  logic          o_done;

  shift_register_universal #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_en          (i_en),
    .i_op          (i_op),
    .i_par_in      (i_par_in),
    .i_ser_in_l    (i_ser_in_l),
    .i_ser_in_r    (i_ser_in_r),
    .i_burst_start (i_burst_start),
    .i_burst_len   (i_burst_len),
    .i_burst_dir   (i_burst_dir),
    .o_par_out     (o_par_out),
    .o_ser_out_l   (o_ser_out_l),
    .o_ser_out_r   (o_ser_out_r),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: value as an integer, burst as a remaining-shift count.
  int m_q    = 0;
  int m_rem  = 0;
  int m_dir  = 0;
  int m_busy = 0;
  int m_done = 0;

`ifdef SHIFT_REG_ROTATE_EN
  localparam bit RotEn = 1'b1;
`else
  localparam bit RotEn = 1'b0;
`endif

  function automatic int apply_op(input int q, input int op);
    case (op)
      1:       return int'(i_par_in);
      2:       return ((q * 2) + int'(i_ser_in_l)) % 256;
      3:       return (q / 2) + 128 * int'(i_ser_in_r);
      4:       return (q / 2) + (q >= 128 ? 128 : 0);
      5:       return RotEn ? ((q * 2) % 256) + (q / 128) : q;
      6:       return RotEn ? (q / 2) + 128 * (q % 2) : q;
      7:       return 0;
      default: return q;
    endcase
  endfunction

  task automatic model_step();
    int nd = 0;
    if (m_rem > 0) begin
      m_q = apply_op(m_q, m_dir ? 3 : 2);
      m_rem--;
      if (m_rem == 0) nd = 1;
    end else if (i_burst_start) begin
      if (i_burst_len == 0) nd = 1;
      else begin
        m_rem = (int'(i_burst_len) > W) ? W : int'(i_burst_len);
        m_dir = int'(i_burst_dir);
      end
    end else if (i_en) begin
      m_q = apply_op(m_q, int'(i_op));
    end
    m_done = nd;
    m_busy = (m_rem > 0) ? 1 : 0;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".par_out"}, int'(o_par_out), m_q);
    chk({tag, ".busy"}, int'(o_busy), m_busy);
    chk({tag, ".done"}, int'(o_done), m_done);
    chk({tag, ".ser_l"}, int'(o_ser_out_l), m_q / 128);
    chk({tag, ".ser_r"}, int'(o_ser_out_r), m_q % 2);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    chk_model(tag);
  endtask

  task automatic do_op(input int op, input int data, input string tag);
    i_en = 1'b1;
    i_op = 3'(op);
    i_par_in = 8'(data);
    tick(tag);
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    reset = 1'b1;
    i_en = 1'b0; i_op = 3'd0; i_par_in = '0; i_ser_in_l = 1'b0; i_ser_in_r = 1'b0;
    i_burst_start = 1'b0; i_burst_len = '0; i_burst_dir = 1'b0;
    #12;
    chk("reset.par_out", int'(o_par_out), 0);
    chk("reset.busy", int'(o_busy), 0);
    chk("reset.done", int'(o_done), 0);
    reset = 1'b0;
    tick("idle");

    do_op(1, 8'hA5, "load");        chk("load_a5", int'(o_par_out), 8'hA5);
    do_op(0, 8'h00, "hold");        chk("hold", int'(o_par_out), 8'hA5);
    i_en = 1'b0; i_op = 3'd1; tick("en0");
    chk("en0_load", int'(o_par_out), 8'hA5);
    i_ser_in_l = 1'b1;
    do_op(2, 0, "shl");             chk("shl", int'(o_par_out), 8'h4B);
    do_op(1, 8'hA5, "reload");
    i_ser_in_r = 1'b0;
    do_op(3, 0, "shr");             chk("shr", int'(o_par_out), 8'h52);
    do_op(1, 8'hA5, "reload");
    do_op(4, 0, "asr");             chk("asr", int'(o_par_out), 8'hD2);
    do_op(7, 0, "clear");           chk("clear", int'(o_par_out), 0);
    do_op(1, 8'h81, "load81");
    do_op(5, 0, "rol");             chk("rol", int'(o_par_out), RotEn ? 8'h03 : 8'h81);
    do_op(1, 8'h81, "load81");
    do_op(6, 0, "ror");             chk("ror", int'(o_par_out), RotEn ? 8'hC0 : 8'h81);

    // Left burst of 3 with CLEAR presented the whole time.
    do_op(1, 8'hF0, "loadf0");
    i_op = 3'd7; i_en = 1'b1; i_ser_in_l = 1'b0;
    i_burst_start = 1'b1; i_burst_len = CW'(3); i_burst_dir = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    tick("b3.e0");
    i_burst_start = 1'b0;
    busy_cnt += int'(o_busy);
    for (int i = 0; i < 3; i++) begin
      tick("b3.run");
      busy_cnt += int'(o_busy);
      done_cnt += int'(o_done);
    end
    i_en = 1'b0;
    tick("b3.after");
    done_cnt += int'(o_done);
    chk("b3.busy_cycles", busy_cnt, 3);
    chk("b3.done_pulses", done_cnt, 1);
    chk("b3.result", int'(o_par_out), 8'h80);

    // Zero-length burst: done only, no data change.
    i_burst_start = 1'b1; i_burst_len = '0;
    tick("b0.e0");
    chk("b0.done", int'(o_done), 1);
    chk("b0.busy", int'(o_busy), 0);
    i_burst_start = 1'b0;
    tick("b0.next");
    chk("b0.data", int'(o_par_out), 8'h80);

    // Saturating right burst.
    do_op(1, 8'hFF, "loadff");
    i_en = 1'b0; i_ser_in_r = 1'b0;
    i_burst_start = 1'b1; i_burst_len = CW'(12); i_burst_dir = 1'b1;
    busy_cnt = 0;
    tick("b12.e0");
    i_burst_start = 1'b0;
    busy_cnt += int'(o_busy);
    for (int i = 0; i < 8; i++) begin
      tick("b12.run");
      busy_cnt += int'(o_busy);
    end
    chk("b12.busy_cycles", busy_cnt, 8);
    chk("b12.result", int'(o_par_out), 0);
    chk("b12.done", int'(o_done), 1);

    // Reset in the middle of a burst.
    do_op(1, 8'hFF, "loadff2");
    i_en = 1'b0; i_ser_in_l = 1'b0;
    i_burst_start = 1'b1; i_burst_len = CW'(6); i_burst_dir = 1'b0;
    tick("b6.e0");
    i_burst_start = 1'b0;
    tick("b6.s1");
    tick("b6.s2");
    chk("b6.two_shifts", int'(o_par_out), 8'hFC);
    #2 reset = 1'b1;
    m_q = 0; m_rem = 0; m_busy = 0; m_done = 0;
    #1;
    chk_model("b6.reset");
    #2 reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick("b6.post");
      done_cnt += int'(o_done);
    end
    chk("b6.no_done", done_cnt, 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      i_en          = 1'($urandom_range(0, 3) != 0);
      i_op          = 3'($urandom_range(0, 7));
      i_par_in      = 8'($urandom);
      i_ser_in_l    = 1'($urandom);
      i_ser_in_r    = 1'($urandom);
      i_burst_start = 1'($urandom_range(0, 7) == 0);
      i_burst_len   = CW'($urandom_range(0, 15));
      i_burst_dir   = 1'($urandom);
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
